// File: rtl/instruction_fetch.sv
// Fetch stage of the multi-cycle RV32I core: owns the PC, reads one word per instruction
// over a req/ready handshake and hands it to decode. Optional issue counter: IF_FETCH_COUNT_EN.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        WB_kick_up,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instruction,
  output logic [31:0] IF_pc,
  output logic        IF_kick_up,
  output logic        fetch_error,
  output logic [31:0] fetch_count
);

  localparam logic [2:0] S_START = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam int              TMR_W    = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam bit              TMR_EN   = (FETCH_TIMEOUT != 0);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FETCH_TIMEOUT - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [31:0]      pc;
  logic [TMR_W-1:0] tmr;
  logic             capture;
  logic             timeout_hit;
  logic             retire;
  logic             unused_tgt_lsb;

  // Branch targets are forced to word alignment; the low bits carry no meaning here.
  function automatic logic [31:0] next_pc(input logic [31:0] pc_cur,
                                          input logic        taken,
                                          input logic [29:0] target_word);
    return taken ? {target_word, 2'b00} : pc_cur + 32'd4;
  endfunction

  assign unused_tgt_lsb = ^branch_target[1:0];

  assign capture     = (state == S_FETCH) && imem_ready;
  assign timeout_hit = (state == S_FETCH) && !imem_ready && TMR_EN && (tmr == TMR_LAST);
  assign retire      = (state == S_HOLD) && WB_kick_up;

  always_comb begin
    state_nxt = state;
    case (state)
      S_START: state_nxt = S_FETCH;
      S_FETCH: begin
        if (capture)          state_nxt = S_ISSUE;
        else if (timeout_hit) state_nxt = S_HALT;
      end
      S_ISSUE: state_nxt = S_HOLD;
      S_HOLD:  if (retire) state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_START;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_START;
      pc          <= RESET_PC;
      tmr         <= '0;
      instruction <= 32'h0;
      IF_pc       <= 32'h0;
      fetch_error <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH) begin
        tmr <= capture ? '0 : tmr + TMR_W'(1);
      end
      if (capture) begin
        instruction <= imem_rdata;
        IF_pc       <= pc;
      end
      if (timeout_hit) begin
        fetch_error <= 1'b1;
      end
      if (retire) begin
        pc <= next_pc(pc, branch_taken, branch_target[31:2]);
      end
    end
  end

  // Handshake outputs are pure decodes of the state register, so reset drops them instantly.
  assign imem_req   = (state == S_FETCH);
  assign IF_kick_up = (state == S_ISSUE);
  assign imem_addr  = pc;

`ifdef IF_FETCH_COUNT_EN
  logic [31:0] issue_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_cnt <= 32'h0;
    end else if (state == S_ISSUE) begin
      issue_cnt <= issue_cnt + 32'd1;
    end
  end

  assign fetch_count = issue_cnt;
`else
  assign fetch_count = 32'h0;
`endif

endmodule
